multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multicycle RISC-V control FSM. It is the producer side of the ALU's control interface.
- Per instruction, it sequences fetch, decode, execute, memory and writeback.
- It drives ALUControl and all datapath select/enable lines, and consumes the ALU zero flag for beq.
- Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.

Parameters:
- RESET_STATE, 4'd0, FSM encoding loaded on reset (FETCH).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- op  input  7  instr[6:0] from the instruction register
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- zero  input  1  ALU zero flag, combinational from the current ALU result
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0=PC, 1=Result
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction/OldPC register enable
- ResultSrc  output  2  00=ALUOut, 01=read Data, 10=ALUResult
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=constant 4
- ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
- RegWrite  output  1  register file write enable
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_op  output  1  one-cycle pulse in DECODE on an unsupported opcode
- instr_done  output  1  one-cycle pulse in the final state of each instruction
- state  output  4  current FSM state, for debug

Behaviour:
- Reset and clocking:
  - Reset is asynchronous and active-low; the state register clears on the falling edge of rst_n.
  - Outputs are Moore-decoded from state, except PCWrite, ImmSrc and ALUControl, which also depend on their inputs.
  - In reset: state=FETCH, IRWrite=1 and PCWrite=1 as FETCH decodes; memory and register writes stay 0.
  - The first instruction fetch occurs on the first rising edge after rst_n deasserts.
  - Asserting reset mid-instruction aborts it immediately; no further MemWrite or RegWrite occurs.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11-15 return to FETCH on the next edge.
- Per-state outputs (unlisted enables=0, unlisted selects=00):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1, instr_done=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, instr_done=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1, instr_done=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- Transitions:
  - FETCH->DECODE.
  - DECODE by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - other -> FETCH, with illegal_op=1 that cycle
  - MEMADR: lw->MEMREAD, sw->MEMWRITE.
  - MEMREAD->MEMWB; EXECUTER and EXECUTEI->ALUWB; JAL->ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
- Cycles per instruction: lw 5, sw 4, R/I 4, jal 4, beq 3.
- PCWrite = PCUpdate | (Branch & zero). zero is sampled in the BEQ cycle itself; no registering.
- ImmSrc is combinational from op:
  - lw or 0010011: 00
  - sw: 01
  - beq: 10
  - jal: 11
  - else: 00
- ALU decode:
  - ALUOp=00 -> 000; ALUOp=01 -> 001.
  - ALUOp=10, by funct3:
    - 000 -> 001 if (op[5] & funct7b5), else 000. addi with instr[30]=1 stays add.
    - 010 -> 101
    - 110 -> 011
    - 111 -> 010
    - other -> 000 (unsupported; no flag)
- ALUControl never takes the value 100, 110 or 111.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> state=0, IRWrite=1, PCWrite=1, MemWrite=0, RegWrite=0. After one edge, state=1.
- lw (op=0000011): state sequence 0,1,2,3,4,0. In state 2, ALUSrcB=01 and ALUControl=000. In state 4, RegWrite=1, ResultSrc=01 and instr_done=1. MemWrite stays 0 throughout.
- R-type sub (op=0110011, funct3=000, funct7b5=1): in EXECUTER, ALUControl=001. With funct3=010, ALUControl=101. For addi with funct7b5=1 (op=0010011), ALUControl=000.
- beq: with zero=1 in the BEQ cycle, PCWrite=1 and ImmSrc=10. With zero=0, PCWrite=0. Either way FETCH follows, giving 3 cycles.
- Illegal op=1111111: DECODE pulses illegal_op=1 for one cycle, then FETCH; no MemWrite or RegWrite is asserted.
- Reset mid-sw: drop rst_n while state=2 -> state=0 asynchronously before the next edge, and MemWrite never asserts.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control interface between multicycle controller and datapath
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic [2:0] ALUControl;
    logic       illegal_op;
    logic       instr_done;
    logic [3:0] state;

    // Controller side: consumes instruction fields and zero, drives all control lines.
    modport master (
        input  op, funct3, funct7b5, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUControl, illegal_op, instr_done, state
    );

    // Datapath side.
    modport slave (
        output op, funct3, funct7b5, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUControl, illegal_op, instr_done, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RISC-V control FSM with ALU and immediate decode
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_e     state_q, state_d;
    logic       pc_update;
    logic       branch;
    logic [1:0] alu_op;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= state_e'(RESET_STATE);
        else        state_q <= state_d;
    end

    // Next-state and Moore-decoded control outputs.
    always_comb begin
        state_d        = FETCH;
        pc_update      = 1'b0;
        branch         = 1'b0;
        alu_op         = 2'b00;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.RegWrite   = 1'b0;
        bus.illegal_op = 1'b0;
        bus.instr_done = 1'b0;
        case (state_q)
            FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                pc_update     = 1'b1;
                state_d       = DECODE;
            end
            DECODE: begin
                // Branch target is computed here so BEQ can use ALUOut.
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default: begin
                        state_d        = FETCH;
                        bus.illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                state_d     = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                bus.AdrSrc = 1'b1;
                state_d    = MEMWB;
            end
            MEMWB: begin
                bus.ResultSrc  = 2'b01;
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            MEMWRITE: begin
                bus.AdrSrc     = 1'b1;
                bus.MemWrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            EXECUTER: begin
                bus.ALUSrcA = 2'b10;
                alu_op      = 2'b10;
                state_d     = ALUWB;
            end
            EXECUTEI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                alu_op      = 2'b10;
                state_d     = ALUWB;
            end
            ALUWB: begin
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            BEQ: begin
                bus.ALUSrcA    = 2'b10;
                alu_op         = 2'b01;
                branch         = 1'b1;
                bus.instr_done = 1'b1;
            end
            JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                pc_update   = 1'b1;
                state_d     = ALUWB;
            end
            default: state_d = FETCH;
        endcase
    end

    // Immediate format select follows the opcode directly.
    always_comb begin
        case (bus.op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BEQ:  bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

    // ALU decode; subtract only for R-type so addi ignores instr[30].
    always_comb begin
        bus.ALUControl = 3'b000;
        case (alu_op)
            2'b01: bus.ALUControl = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  bus.ALUControl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  bus.ALUControl = 3'b101;
                    3'b110:  bus.ALUControl = 3'b011;
                    3'b111:  bus.ALUControl = 3'b010;
                    default: bus.ALUControl = 3'b000;
                endcase
            end
            default: bus.ALUControl = 3'b000;
        endcase
    end

    assign bus.PCWrite = pc_update | (branch & bus.zero);
    assign bus.state   = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    multicycle_controller_if bus ();

    multicycle_controller #(.RESET_STATE(4'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       rw;
        logic [1:0] aop;
        logic       pcu;
        logic       br;
        logic       done;
    } row_t;

    // kinds: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 illegal
    row_t tbl [11];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] kind_op(input int kind);
        case (kind)
            0: return 7'b0000011;
            1: return 7'b0100011;
            2: return 7'b0110011;
            3: return 7'b0010011;
            4: return 7'b1100011;
            5: return 7'b1101111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic bit is_supported(input logic [6:0] o);
        for (int k = 0; k < 6; k++) if (kind_op(k) == o) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] alu_ref(input logic [1:0] aop, input int kind,
                                           input logic [2:0] f3, input logic f7);
        if (aop == 2'b00) return 3'b000;
        if (aop == 2'b01) return 3'b001;
        case (f3)
            3'b000:  return (kind == 2 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] imm_ref(input int kind);
        case (kind)
            1: return 2'b01;
            4: return 2'b10;
            5: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check_state_outputs(input int s, input int kind, input logic [2:0] f3,
                                       input logic f7, input logic z);
        row_t r;
        r = tbl[s];
        check_eq("state", bus.state, s);
        check_eq("AdrSrc", bus.AdrSrc, r.adr);
        check_eq("MemWrite", bus.MemWrite, r.mw);
        check_eq("IRWrite", bus.IRWrite, r.irw);
        check_eq("ResultSrc", bus.ResultSrc, r.rs);
        check_eq("ALUSrcA", bus.ALUSrcA, r.sa);
        check_eq("ALUSrcB", bus.ALUSrcB, r.sb);
        check_eq("RegWrite", bus.RegWrite, r.rw);
        check_eq("PCWrite", bus.PCWrite, r.pcu | (r.br & z));
        check_eq("instr_done", bus.instr_done, r.done);
        check_eq("ALUControl", bus.ALUControl, alu_ref(r.aop, kind, f3, f7));
        check_eq("ImmSrc", bus.ImmSrc, imm_ref(kind));
        check_eq("illegal_op", bus.illegal_op, (s == 1 && kind == 6));
    endtask

    // One instruction from FETCH; zmode 0/1 forces zero, 2 randomizes it every cycle.
    // abort_at >= 0 drops reset asynchronously while in that path position.
    task automatic run_instr(input int kind, input logic [2:0] f3, input logic f7,
                             input int zmode, input int abort_at);
        int path[$];
        logic [6:0] o;
        case (kind)
            0: path = '{0, 1, 2, 3, 4};
            1: path = '{0, 1, 2, 5};
            2: path = '{0, 1, 6, 8};
            3: path = '{0, 1, 7, 8};
            4: path = '{0, 1, 9};
            5: path = '{0, 1, 10, 8};
            default: path = '{0, 1};
        endcase
        o = kind_op(kind);
        if (kind == 6) begin
            o = 7'($urandom);
            while (is_supported(o)) o = 7'($urandom);
        end
        bus.op = o;
        bus.funct3 = f3;
        bus.funct7b5 = f7;
        foreach (path[i]) begin
            bus.zero = (zmode == 2) ? 1'($urandom) : zmode[0];
            @(negedge clk);
            check_state_outputs(path[i], kind, f3, f7, bus.zero);
            if (i == abort_at) begin
                #1 rst_n = 1'b0;
                #1;
                check_eq("abort_state", bus.state, 0);
                check_eq("abort_memwrite", bus.MemWrite, 0);
                check_eq("abort_regwrite", bus.RegWrite, 0);
                @(posedge clk);
                #1;
                check_eq("abort_hold_state", bus.state, 0);
                check_eq("abort_hold_memwrite", bus.MemWrite, 0);
                rst_n = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tbl[0]  = '{adr:0, mw:0, irw:1, rs:2'b10, sa:2'b00, sb:2'b10, rw:0, aop:2'b00, pcu:1, br:0, done:0};
        tbl[1]  = '{adr:0, mw:0, irw:0, rs:2'b00, sa:2'b01, sb:2'b01, rw:0, aop:2'b00, pcu:0, br:0, done:0};
        tbl[2]  = '{adr:0, mw:0, irw:0, rs:2'b00, sa:2'b10, sb:2'b01, rw:0, aop:2'b00, pcu:0, br:0, done:0};
        tbl[3]  = '{adr:1, mw:0, irw:0, rs:2'b00, sa:2'b00, sb:2'b00, rw:0, aop:2'b00, pcu:0, br:0, done:0};
        tbl[4]  = '{adr:0, mw:0, irw:0, rs:2'b01, sa:2'b00, sb:2'b00, rw:1, aop:2'b00, pcu:0, br:0, done:1};
        tbl[5]  = '{adr:1, mw:1, irw:0, rs:2'b00, sa:2'b00, sb:2'b00, rw:0, aop:2'b00, pcu:0, br:0, done:1};
        tbl[6]  = '{adr:0, mw:0, irw:0, rs:2'b00, sa:2'b10, sb:2'b00, rw:0, aop:2'b10, pcu:0, br:0, done:0};
        tbl[7]  = '{adr:0, mw:0, irw:0, rs:2'b00, sa:2'b10, sb:2'b01, rw:0, aop:2'b10, pcu:0, br:0, done:0};
        tbl[8]  = '{adr:0, mw:0, irw:0, rs:2'b00, sa:2'b00, sb:2'b00, rw:1, aop:2'b00, pcu:0, br:0, done:1};
        tbl[9]  = '{adr:0, mw:0, irw:0, rs:2'b00, sa:2'b10, sb:2'b00, rw:0, aop:2'b01, pcu:0, br:1, done:1};
        tbl[10] = '{adr:0, mw:0, irw:0, rs:2'b00, sa:2'b01, sb:2'b10, rw:0, aop:2'b00, pcu:1, br:0, done:0};

        bus.op = 7'b0000011;
        bus.funct3 = 3'b000;
        bus.funct7b5 = 1'b0;
        bus.zero = 1'b0;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", bus.state, 0);
        check_eq("rst_irwrite", bus.IRWrite, 1);
        check_eq("rst_pcwrite", bus.PCWrite, 1);
        check_eq("rst_memwrite", bus.MemWrite, 0);
        check_eq("rst_regwrite", bus.RegWrite, 0);
        rst_n = 1'b1;

        // Directed: lw, sub, slt, addi with instr[30], beq taken/not taken, illegal, jal.
        run_instr(0, 3'b010, 1'b0, 0, -1);
        run_instr(2, 3'b000, 1'b1, 0, -1);
        run_instr(2, 3'b010, 1'b0, 0, -1);
        run_instr(3, 3'b000, 1'b1, 0, -1);
        run_instr(4, 3'b000, 1'b0, 1, -1);
        run_instr(4, 3'b000, 1'b0, 0, -1);
        run_instr(6, 3'b000, 1'b0, 0, -1);
        run_instr(5, 3'b000, 1'b0, 2, -1);
        // Reset while sw is in MEMADR.
        run_instr(1, 3'b010, 1'b0, 0, 2);
        run_instr(1, 3'b010, 1'b0, 0, -1);

        // Random instruction mix.
        for (int n = 0; n < 300; n++) begin
            run_instr(int'($urandom_range(0, 6)), 3'($urandom), 1'($urandom), 2, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
